// File: rtl/sig_div_seq.sv
// sig_div_seq: iterative restoring divider for normalized significands, one quotient bit per clock
module sig_div_seq #(
    parameter int NEXP = 8,
    parameter int NSIG = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NSIG:0] a_sig,
    input  logic [NSIG:0] b_sig,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NSIG+1:0] q,
    output logic          sticky,
    output logic          err
);
    localparam int CW = $clog2(NSIG + 3);

    if (NEXP < 1) begin : g_nexp_chk
        $error("NEXP must be positive");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nx;
    logic [NSIG+1:0] r, r_nx, q_nx, diff, sel;
    logic [NSIG:0]   b, b_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            sticky_nx, err_nx, qb;

    // state, operand and result registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            r      <= '0;
            b      <= '0;
            cnt    <= '0;
            q      <= '0;
            sticky <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            r      <= r_nx;
            b      <= b_nx;
            cnt    <= cnt_nx;
            q      <= q_nx;
            sticky <= sticky_nx;
            err    <= err_nx;
        end
    end

    // next-state and datapath: trial subtract, restore on negative, shift left
    always_comb begin
        state_nx  = state;
        r_nx      = r;
        b_nx      = b;
        cnt_nx    = cnt;
        q_nx      = q;
        sticky_nx = sticky;
        err_nx    = err;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        qb        = (r >= {1'b0, b});
        diff      = r - {1'b0, b};
        sel       = qb ? diff : r;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    b_nx   = b_sig;
                    r_nx   = {1'b0, a_sig};
                    cnt_nx = CW'(NSIG + 2);
                    if (!b_sig[NSIG]) begin
                        q_nx      = '1;
                        sticky_nx = 1'b0;
                        err_nx    = 1'b1;
                        state_nx  = DONE;
                    end else begin
                        q_nx     = '0;
                        err_nx   = 1'b0;
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                r_nx   = {sel[NSIG:0], 1'b0};
                q_nx   = {q[NSIG:0], qb};
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    sticky_nx = (r_nx != '0);
                    state_nx  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sig_div_seq.sv
// tb_sig_div_seq: directed vectors for sig_div_seq with a queue scoreboard and an independent monitor
module tb_sig_div_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_sig = '0;
    logic [7:0] b_sig = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] q;
    logic       sticky;
    logic       err;

    typedef struct {
        logic [8:0] q;
        logic       s;
        logic       e;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    int   acc_edge = 0;
    logic seen = 1'b0;

    sig_div_seq #(.NEXP(8), .NSIG(7)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_sig(a_sig), .b_sig(b_sig), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .sticky(sticky), .err(err)
    );

    always #5 clk = ~clk;

    // edge counter used to measure result latency from the accepting edge
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compare each newly presented result against the oldest expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (out_valid && !seen) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got q=%0h with empty scoreboard", q);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("q", int'(q), int'(e.q));
                    check("sticky", int'(sticky), int'(e.s));
                    check("err", int'(err), int'(e.e));
                    check("latency", edge_cnt - acc_edge, e.lat);
                end
            end
            seen = out_valid;
        end
    end

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [8:0] eq,
                      input logic es, input logic ee, input int el, input int hold);
        int n;
        exp_t x;
        @(negedge clk);
        in_valid = 1'b1;
        a_sig = a;
        b_sig = b;
        x.q = eq; x.s = es; x.e = ee; x.lat = el;
        sb.push_back(x);
        @(posedge clk);
        #1;
        acc_edge = edge_cnt;
        a_sig = ~a;
        b_sig = 8'h80;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL timeout: out_valid low after %0d cycles, expected high", n);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_q", int'(q), int'(eq));
            check("hold_sticky", int'(sticky), int'(es));
            check("hold_err", int'(err), int'(ee));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_q", int'(q), 0);
        check("rst_sticky", int'(sticky), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        op(8'h80, 8'h80, 9'h100, 1'b0, 1'b0, 9, 0);
        op(8'h80, 8'hC0, 9'h0AA, 1'b1, 1'b0, 9, 0);
        op(8'hC0, 8'h80, 9'h180, 1'b0, 1'b0, 9, 0);
        op(8'hFF, 8'h80, 9'h1FE, 1'b0, 1'b0, 9, 0);
        op(8'h80, 8'h40, 9'h1FF, 1'b0, 1'b1, 0, 0);
        op(8'h80, 8'h00, 9'h1FF, 1'b0, 1'b1, 0, 2);
        op(8'hC0, 8'hA0, 9'h133, 1'b1, 1'b0, 9, 5);
        @(negedge clk);
        in_valid = 1'b1;
        a_sig = 8'hC0;
        b_sig = 8'hA0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_q", int'(q), 0);
        check("abort_sticky", int'(sticky), 0);
        check("abort_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op(8'hC0, 8'hA0, 9'h133, 1'b1, 1'b0, 9, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
